// File: rtl/avr_cpu_reg_writeback.sv
`default_nettype none
// ============================================================================
// Module   : avr_cpu_reg_writeback
// Function : Serializes queued byte/pair writes onto the single register-file
//            d port; refreshes the addressed register when no write is due.
// Revision : 1.0
// ============================================================================
module avr_cpu_reg_writeback #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_addr,
    input  logic        req_wide,
    input  logic [15:0] req_data,
    input  logic [4:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic        rd_stall,
    output logic [4:0]  rf_d_addr,
    output logic [7:0]  rf_d_in,
    input  logic [7:0]  rf_d_out
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] C_PONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;

    logic [4:0]  r_mem_addr [DEPTH];
    logic        r_mem_wide [DEPTH];
    logic [15:0] r_mem_data [DEPTH];

    logic        w_push;
    logic        w_pop;
    logic [4:0]  w_head_addr;
    logic        w_head_wide;
    logic [15:0] w_head_data;

    assign w_head_addr = r_mem_addr[r_rd_ptr];
    assign w_head_wide = r_mem_wide[r_rd_ptr];
    assign w_head_data = r_mem_data[r_rd_ptr];

    // Ready depends only on the registered occupancy and the reset pin.
    assign req_ready = rst && (r_count < C_DEPTH);
    assign w_push    = req_valid && req_ready;
    assign w_pop     = ((r_state == WR_LO) && !w_head_wide) || (r_state == WR_HI);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + C_ONE;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - C_ONE;
        end
    end

    // Leaving IDLE on the accepting edge lets a byte hit the port the next cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if ((r_count != '0) || w_push) begin
                    w_state_next = WR_LO;
                end
            end
            WR_LO: begin
                if (w_head_wide) begin
                    w_state_next = WR_HI;
                end else if (w_count_next != '0) begin
                    w_state_next = WR_LO;
                end else begin
                    w_state_next = IDLE;
                end
            end
            WR_HI: begin
                if (w_count_next != '0) begin
                    w_state_next = WR_LO;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PONE;
            end
        end
    end

    // Pair writes always start on the even register of the pair.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= req_wide ? {req_addr[4:1], 1'b0} : req_addr;
            r_mem_wide[r_wr_ptr] <= req_wide;
            r_mem_data[r_wr_ptr] <= req_data;
        end
    end

    always_comb begin
        rf_d_addr = rd_addr;
        rf_d_in   = rf_d_out;
        case (r_state)
            WR_LO: begin
                rf_d_addr = w_head_addr;
                rf_d_in   = w_head_data[7:0];
            end
            WR_HI: begin
                rf_d_addr = {w_head_addr[4:1], 1'b1};
                rf_d_in   = w_head_data[15:8];
            end
            default: begin
                rf_d_addr = rd_addr;
                rf_d_in   = rf_d_out;
            end
        endcase
    end

    // No forwarding: any pending write holds the decoder off.
    assign rd_stall = !rst || (r_state != IDLE) || (r_count != '0);
    assign rd_data  = rd_stall ? 8'h00 : rf_d_out;

endmodule
`default_nettype wire
